// File: rtl/io_board_interface.sv
// Board-side IO bridge: debounces KEY/SW pins into io_input_bus and registers
// io_output_bus onto the HEX segment and LED pins.
module io_board_interface #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 20,
   parameter bit HEX_ACTIVE_LOW  = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  key_pins,
   input  logic [9:0]  sw_pins,
   output logic [13:0] io_input_bus,
   input  logic [51:0] io_output_bus,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [9:0]  led
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [6:0]           SEG_MASK = {7{HEX_ACTIVE_LOW}};

   // Keys are inverted ahead of the synchronizer so a released key resets to 0
   logic [13:0] w_raw;
   assign w_raw = {~key_pins, sw_pins};

   logic [13:0] r_sync1;
   logic [13:0] r_sync2;
   logic [13:0] r_stable;

   genvar gi;
   generate
      for (gi = 0; gi < 14; gi++) begin : g_chan
         logic [CNT_WIDTH-1:0] r_cnt;

         always_ff @(posedge clock) begin
            if (!reset) begin
               r_sync1[gi]  <= 1'b0;
               r_sync2[gi]  <= 1'b0;
               r_stable[gi] <= 1'b0;
               r_cnt        <= '0;
            end else begin
               r_sync1[gi] <= w_raw[gi];
               r_sync2[gi] <= r_sync1[gi];
               if (r_sync2[gi] == r_stable[gi]) begin
                  r_cnt <= '0;
               end else if (r_cnt == CNT_MAX) begin
                  r_stable[gi] <= r_sync2[gi];
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
         end
      end
   endgenerate

   assign io_input_bus = r_stable;

   logic [51:0] r_out;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_out <= '0;
      end else begin
         r_out <= io_output_bus;
      end
   end

   // Inversion by a constant mask only, so the pins stay directly registered
   assign hex0 = r_out[16:10] ^ SEG_MASK;
   assign hex1 = r_out[23:17] ^ SEG_MASK;
   assign hex2 = r_out[30:24] ^ SEG_MASK;
   assign hex3 = r_out[37:31] ^ SEG_MASK;
   assign hex4 = r_out[44:38] ^ SEG_MASK;
   assign hex5 = r_out[51:45] ^ SEG_MASK;
   assign led  = r_out[9:0];

endmodule

// File: tb/tb_io_board_interface.sv
// Directed bench for io_board_interface with DEBOUNCE_CYCLES=4, active-low HEX.
module tb_io_board_interface;

   logic        clock;
   logic        reset;
   logic [3:0]  key_pins;
   logic [9:0]  sw_pins;
   logic [13:0] io_input_bus;
   logic [51:0] io_output_bus;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic [9:0]  led;

   int n_checks = 0;
   int n_fail   = 0;

   io_board_interface #(
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH(4),
      .HEX_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key_pins(key_pins),
      .sw_pins(sw_pins),
      .io_input_bus(io_input_bus),
      .io_output_bus(io_output_bus),
      .hex0(hex0),
      .hex1(hex1),
      .hex2(hex2),
      .hex3(hex3),
      .hex4(hex4),
      .hex5(hex5),
      .led(led)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // One rising edge, then settle 1 time unit before sampling or driving
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset         = 1'b0;
      key_pins      = 4'hF;
      sw_pins       = 10'h000;
      io_output_bus = '0;

      // Reset state
      tick();
      tick();
      check("rst_bus", 64'(io_input_bus), 64'h0);
      check("rst_hex0", 64'(hex0), 64'h7F);
      check("rst_hex1", 64'(hex1), 64'h7F);
      check("rst_hex2", 64'(hex2), 64'h7F);
      check("rst_hex3", 64'(hex3), 64'h7F);
      check("rst_hex4", 64'(hex4), 64'h7F);
      check("rst_hex5", 64'(hex5), 64'h7F);
      check("rst_led", 64'(led), 64'h0);

      reset = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("idle_bus", 64'(io_input_bus), 64'h0);

      // Switch debounce: accepted after edge 6
      sw_pins[0] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("sw0_e%0d", e), 64'(io_input_bus), (e <= 5) ? 64'h0 : 64'h001);
      end

      // Glitch of 3 cycles on KEY2 is rejected
      key_pins[2] = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      key_pins[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i % 4 == 3 || i == 19)
            check($sformatf("glitch_c%0d", i), 64'(io_input_bus), 64'h001);
      end

      // KEY3 press with SW9 raised at the same time
      key_pins[3] = 1'b0;
      sw_pins[9]  = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e >= 5)
            check($sformatf("press_e%0d", e), 64'(io_input_bus), (e == 5) ? 64'h0001 : 64'h2201);
      end
      key_pins[3] = 1'b1;
      sw_pins[9]  = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e >= 5)
            check($sformatf("release_e%0d", e), 64'(io_input_bus), (e == 5) ? 64'h2201 : 64'h0001);
      end

      // Output path: values held until the capturing edge
      io_output_bus = {7'h06, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F, 10'h2A5};
      check("out_hold_hex0", 64'(hex0), 64'h7F);
      check("out_hold_led", 64'(led), 64'h0);
      tick();
      check("out_hex0", 64'(hex0), 64'h40);
      check("out_hex1", 64'(hex1), 64'h7F);
      check("out_hex2", 64'(hex2), 64'h7F);
      check("out_hex3", 64'(hex3), 64'h7F);
      check("out_hex4", 64'(hex4), 64'h7F);
      check("out_hex5", 64'(hex5), 64'h79);
      check("out_led", 64'(led), 64'h2A5);

      // Reset mid-count discards the partial debounce of SW4
      sw_pins[4] = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b0;
      tick();
      check("midrst_bus", 64'(io_input_bus), 64'h0);
      check("midrst_hex0", 64'(hex0), 64'h7F);
      check("midrst_led", 64'(led), 64'h0);
      reset = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("postrst_e%0d", e), 64'(io_input_bus), (e <= 5) ? 64'h0 : 64'h011);
      end
      check("postrst_led", 64'(led), 64'h2A5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
